// File: rtl/fir_mac_ctrl.sv
// FIR MAC sequencer: owns the tap delay chain, walks the coefficient SpSram and
// times the MAC multiply/accumulate enables, then holds the result on a valid/ready port.
module fir_mac_ctrl #(
  parameter int TAPS    = 10,
  parameter int DATA_W  = 3,
  parameter int COEFF_W = 16,
  parameter int ADDR_W  = 4,
  parameter int MAC_W   = 16
) (
  input  logic                     iClk12M,
  input  logic                     iRst,
  input  logic                     iInValid,
  input  logic signed [DATA_W-1:0] iInSample,
  output logic                     oInReady,
  output logic                     oDrop,
  output logic [TAPS*DATA_W-1:0]   oDelay,
  output logic                     oCsn,
  output logic [ADDR_W-1:0]        oAddr,
  output logic                     oEnMul,
  output logic                     oEnAddAcc,
  input  logic [MAC_W-1:0]         iMac,
  output logic                     oOutValid,
  output logic [MAC_W-1:0]         oOut,
  input  logic                     iOutReady
);

  // state | meaning
  // IDLE  | waiting for a sample (only accepted once the previous result is consumed)
  // RUN   | rCnt walks 0..TAPS+2 issuing SpSram reads, multiplies, accumulates, capture
  typedef enum logic {IDLE, RUN} state_t;

  localparam int CNT_W = $clog2(TAPS + 3);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] MUL_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] ACC_FIRST = CNT_W'(2);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(TAPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TAPS + 2);

  state_t           state, stateNext;
  logic [CNT_W-1:0] rCnt;
  logic             accept;

  // Ready depends only on registered state so there is no comb path from iOutReady.
  assign oInReady = (state == IDLE) && !oOutValid;
  assign accept   = iInValid && oInReady;

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state     <= IDLE;
      rCnt      <= '0;
      oDelay    <= '0;
      oAddr     <= '0;
      oOut      <= '0;
      oOutValid <= 1'b0;
      oDrop     <= 1'b0;
    end else begin
      state <= stateNext;
      oDrop <= iInValid && !oInReady;
      if (oOutValid && iOutReady)
        oOutValid <= 1'b0;
      if (accept) begin
        oDelay <= {oDelay[TAPS*DATA_W-DATA_W-1:0], iInSample};
        rCnt   <= '0;
        oAddr  <= '0;
      end else if (state == RUN) begin
        if (rCnt == CNT_LAST) begin
          oOut      <= iMac;
          oOutValid <= 1'b1;
        end else begin
          rCnt <= rCnt + 1'b1;
        end
        // Address leads by one so coefficient c is on the bus during cycle c.
        if (rCnt < LAST_ADDR)
          oAddr <= ADDR_W'(rCnt + 1'b1);
      end
    end
  end

  always_comb begin
    stateNext = state;
    oCsn      = 1'b1;
    oEnMul    = 1'b0;
    oEnAddAcc = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)
          stateNext = RUN;
      end
      RUN: begin
        if (rCnt <= LAST_ADDR)
          oCsn = 1'b0;
        if (rCnt >= MUL_FIRST && rCnt <= MUL_LAST)
          oEnMul = 1'b1;
        if (rCnt >= ACC_FIRST && rCnt <= ACC_LAST)
          oEnAddAcc = 1'b1;
        if (rCnt == CNT_LAST)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Bench for fir_mac_ctrl: directed scenarios plus random traffic, every cycle
// compared against a cycle-offset reference model of the sequencer.
module tb_fir_mac_ctrl;
  localparam int TAPS = 10;
  localparam int DATA_W = 3;
  localparam int ADDR_W = 4;
  localparam int MAC_W = 16;

  logic                     iClk12M = 1'b0;
  logic                     iRst = 1'b1;
  logic                     iInValid = 1'b0;
  logic signed [DATA_W-1:0] iInSample = '0;
  logic                     oInReady, oDrop, oCsn, oEnMul, oEnAddAcc, oOutValid;
  logic [TAPS*DATA_W-1:0]   oDelay;
  logic [ADDR_W-1:0]        oAddr;
  logic [MAC_W-1:0]         iMac = '0;
  logic [MAC_W-1:0]         oOut;
  logic                     iOutReady = 1'b0;

  fir_mac_ctrl dut (
    .iClk12M(iClk12M), .iRst(iRst), .iInValid(iInValid), .iInSample(iInSample),
    .oInReady(oInReady), .oDrop(oDrop), .oDelay(oDelay), .oCsn(oCsn), .oAddr(oAddr),
    .oEnMul(oEnMul), .oEnAddAcc(oEnAddAcc), .iMac(iMac), .oOutValid(oOutValid),
    .oOut(oOut), .iOutReady(iOutReady)
  );

  always #5 iClk12M = ~iClk12M;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since accept (-1 when idle), sample history, output register.
  int         mPhase;
  int         mTap [TAPS];
  logic [3:0] mAddr;
  logic       mValid, mDrop;
  logic [15:0] mOut;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] modelDelay();
    logic [29:0] d;
    d = '0;
    for (int k = 0; k < TAPS; k++) d[k*DATA_W +: DATA_W] = mTap[k][2:0];
    return d;
  endfunction

  function automatic logic modelReady();
    return (mPhase < 0) && !mValid;
  endfunction

  task automatic modelReset();
    mPhase = -1;
    for (int k = 0; k < TAPS; k++) mTap[k] = 0;
    mAddr = '0; mValid = 1'b0; mDrop = 1'b0; mOut = '0;
  endtask

  task automatic modelEdge(input logic rst, input logic inV, input logic [2:0] smp,
                           input logic oRdy, input logic [15:0] mac);
    logic wasValid, rdy;
    if (rst) begin
      modelReset();
      return;
    end
    wasValid = mValid;
    rdy = modelReady();
    mDrop = inV && !rdy;
    if (inV && rdy) begin
      for (int k = TAPS - 1; k > 0; k--) mTap[k] = mTap[k-1];
      mTap[0] = smp;
      mPhase = 0;
    end else if (mPhase == TAPS + 2) begin
      mOut = mac;
      mValid = 1'b1;
      mPhase = -1;
    end else if (mPhase >= 0) begin
      mPhase++;
    end
    if (mPhase >= 0 && mPhase < TAPS) mAddr = 4'(mPhase);
    if (wasValid && oRdy) mValid = 1'b0;
  endtask

  task automatic compareAll();
    checkVal("inReady", oInReady, modelReady());
    checkVal("drop", oDrop, mDrop);
    checkVal("delay", oDelay, modelDelay());
    checkVal("csn", oCsn, !(mPhase >= 0 && mPhase < TAPS));
    checkVal("addr", oAddr, mAddr);
    checkVal("enMul", oEnMul, (mPhase >= 1 && mPhase <= TAPS));
    checkVal("enAddAcc", oEnAddAcc, (mPhase >= 2 && mPhase <= TAPS + 1));
    checkVal("outValid", oOutValid, mValid);
    checkVal("out", oOut, mOut);
  endtask

  // Called on a falling edge: check current outputs, drive next inputs, advance model.
  task automatic step(input logic rst, input logic inV, input logic [2:0] smp,
                      input logic oRdy, input logic [15:0] mac);
    compareAll();
    iRst = rst; iInValid = inV; iInSample = smp; iOutReady = oRdy; iMac = mac;
    modelEdge(rst, inV, smp, oRdy, mac);
    @(negedge iClk12M);
  endtask

  // Offer one sample once ready, then let it run and be consumed.
  task automatic runSample(input logic [2:0] smp, input logic [15:0] mac);
    int n;
    n = 0;
    while (!oInReady && n < 40) begin step(1'b0, 1'b0, 3'd0, 1'b1, mac); n++; end
    if (n >= 40) checkVal("readyTimeout", 32'(n), 32'd0);
    step(1'b0, 1'b1, smp, 1'b1, mac);
    for (int i = 0; i < TAPS + 4; i++) step(1'b0, 1'b0, 3'd0, 1'b1, mac);
  endtask

  initial begin
    logic [29:0] held;
    int lat, accCnt, lastAcc, cyc, pulses, drops;
    logic prevValid;

    modelReset();
    repeat (2) @(negedge iClk12M);
    iRst = 1'b0;
    step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0);

    // 1: reset mid-idle
    step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0);
    checkVal("rstCsn", oCsn, 1'b1);
    checkVal("rstInReady", oInReady, 1'b1);
    checkVal("rstOutValid", oOutValid, 1'b0);

    // 2: first sample, latency and pass-through
    step(1'b0, 1'b1, 3'b001, 1'b0, 16'h0123);
    checkVal("delayFirst", oDelay, 30'h1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0123);
      if (oOutValid) begin lat = i; break; end
    end
    checkVal("latency", 32'(lat), 32'd13);
    checkVal("outValue", oOut, 16'h0123);
    step(1'b0, 1'b0, 3'd0, 1'b1, 16'h0);

    // 3: chain ordering and overflow
    runSample(3'd2, 16'h1111);
    runSample(3'd3, 16'h2222);
    checkVal("chain123", oDelay[8:0], 9'b001_010_011);
    for (int s = 4; s <= 11; s++) runSample(3'(s), 16'(s));
    checkVal("oldestTap", oDelay[29:27], 3'd2);

    // 4: back-pressure drops and release
    step(1'b0, 1'b1, 3'd5, 1'b0, 16'hbeef);
    for (int i = 0; i < TAPS + 3; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 16'hbeef);
    held = oDelay;
    step(1'b0, 1'b1, 3'd7, 1'b0, 16'h0);
    checkVal("dropPulse", oDrop, 1'b1);
    checkVal("dropChain", oDelay, held);
    checkVal("dropReady", oInReady, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 16'h0);
    checkVal("releaseValid", oOutValid, 1'b0);
    checkVal("releaseReady", oInReady, 1'b1);
    checkVal("holdOut", oOut, 16'hbeef);

    // 5: reset at rCnt==5, then a full run
    step(1'b0, 1'b1, 3'd6, 1'b1, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd0, 1'b1, 16'h0);
    checkVal("atCnt5", oAddr, 4'd5);
    step(1'b1, 1'b0, 3'd0, 1'b1, 16'h0);
    checkVal("rstRunMul", oEnMul, 1'b0);
    checkVal("rstRunCsn", oCsn, 1'b1);
    checkVal("rstRunDelay", oDelay, 30'h0);
    lat = 0;
    step(1'b0, 1'b1, 3'd1, 1'b0, 16'h0055);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0055);
      if (oOutValid) begin lat = i; break; end
    end
    checkVal("latencyAfterRst", 32'(lat), 32'd13);
    step(1'b0, 1'b0, 3'd0, 1'b1, 16'h0);

    // 6: source offers whenever ready, sink always ready
    accCnt = 0; lastAcc = -1; pulses = 0; drops = 0; prevValid = 1'b0;
    for (cyc = 0; cyc < 200 && accCnt < 4; cyc++) begin
      if (oOutValid && !prevValid) pulses++;
      prevValid = oOutValid;
      if (oDrop) drops++;
      if (oInReady) begin
        if (lastAcc >= 0) checkVal("period", 32'(cyc - lastAcc), 32'd15);
        lastAcc = cyc;
        accCnt++;
      end
      step(1'b0, oInReady, 3'($urandom), 1'b1, 16'($urandom));
    end
    for (int i = 0; i < 20; i++) begin
      if (oOutValid && !prevValid) pulses++;
      prevValid = oOutValid;
      if (oDrop) drops++;
      step(1'b0, 1'b0, 3'd0, 1'b1, 16'h0);
    end
    checkVal("accepts", 32'(accCnt), 32'd4);
    checkVal("validPulses", 32'(pulses), 32'd4);
    checkVal("noDrops", 32'(drops), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) == 0), 1'($urandom), 3'($urandom),
           1'($urandom), 16'($urandom));

    compareAll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
